// File: rtl/down_counter_3bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_3bit_pkg
// Description : Shared widths, step constants and step-select encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package down_counter_3bit_pkg;

    localparam int CNT_WIDTH = 3;

    localparam logic [CNT_WIDTH-1:0] STEP_ONE = 3'd1;
    localparam logic [CNT_WIDTH-1:0] STEP_TWO = 3'd2;

    typedef enum logic {
        STEP_SEL_ONE = 1'b0,
        STEP_SEL_TWO = 1'b1
    } step_sel_e;

    function automatic logic [CNT_WIDTH-1:0] step_value(input step_sel_e sel);
        return (sel == STEP_SEL_TWO) ? STEP_TWO : STEP_ONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/down_counter_3bit_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor / subtractor_3bit
// Description : One-bit full subtractor and a ripple-borrow chain built from it.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module subtractor_3bit
    import down_counter_3bit_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    // w_borrow[i] is the borrow into bit i; bit 0 never borrows in.
    logic [WIDTH:0] w_borrow;

    assign w_borrow[0] = 1'b0;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            full_subtractor u_fs (
                .a    (a[i]),
                .b    (b[i]),
                .bin  (w_borrow[i]),
                .d    (diff[i]),
                .bout (w_borrow[i+1])
            );
        end
    endgenerate

    assign bout = w_borrow[WIDTH];

endmodule
`default_nettype wire

// File: rtl/down_counter_3bit.sv
`default_nettype none
// ============================================================================
// Module      : down_counter_3bit
// Description : Registered down counter, step 1 or 2, with load, borrow pulse
//               and zero flag. Define DOWN_COUNTER_SATURATE_EN to clamp at 0
//               on underflow instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module down_counter_3bit
    import down_counter_3bit_pkg::*;
#(
    parameter int               WIDTH     = CNT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             step_sel,
    output logic [WIDTH-1:0] q,
    output logic             borrow,
    output logic             zero
);

    logic [WIDTH-1:0] r_q;
    logic             r_borrow;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_diff;
    logic             w_bout;
    logic [WIDTH-1:0] w_dec_q;

    assign w_step = WIDTH'(step_value(step_sel_e'(step_sel)));

    subtractor_3bit #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a    (r_q),
        .b    (w_step),
        .diff (w_diff),
        .bout (w_bout)
    );

`ifdef DOWN_COUNTER_SATURATE_EN
    assign w_dec_q = w_bout ? '0 : w_diff;
`else
    assign w_dec_q = w_diff;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= RESET_VAL;
            r_borrow <= 1'b0;
        end else if (load) begin
            r_q      <= load_val;
            r_borrow <= 1'b0;
        end else if (en) begin
            r_q      <= w_dec_q;
            r_borrow <= w_bout;
        end else begin
            r_borrow <= 1'b0;
        end
    end

    assign q      = r_q;
    assign borrow = r_borrow;
    assign zero   = (r_q == '0);

endmodule
`default_nettype wire
